// File: rtl/seq_int_to_fp_converter.sv
// ---------------------------------------------------------------------------
// seq_int_to_fp_converter
//
// Turns a 32-bit integer into an IEEE-754 single-precision value for the fp
// summator datapath. The leading one is found by shifting one bit per cycle,
// then a single round-to-nearest-even step builds the result. One conversion
// is in flight at a time, with a valid/ready handshake on each side.
//
// Ports
//   clk_i      : clock
//   rst_i      : asynchronous, active-high reset
//   int_i      : integer operand, sampled on the accept edge only
//   vld_i      : int_i is valid
//   rdy_o      : converter is idle and can accept (state decode)
//   answer_o   : registered result {sign, exp[7:0], mant[22:0]}
//   vld_o      : answer_o is valid (state decode)
//   rdy_i      : downstream takes the result
//
// Parameters
//   SIGNED_IN  : 1 = int_i is two's complement, 0 = int_i is unsigned
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for vld_i; captures sign, magnitude and exponent
// NORM  | shifts magnitude left until bit 31 is set, one bit per cycle
// ROUND | round-to-nearest-even on the normalised magnitude
// DONE  | answer_o valid, held until rdy_i
// ---------------------------------------------------------------------------
module seq_int_to_fp_converter #(
    parameter int SIGNED_IN = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] int_i,
    input  logic        vld_i,
    output logic        rdy_o,
    output logic [31:0] answer_o,
    output logic        vld_o,
    input  logic        rdy_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // 127 + 31: the exponent of a magnitude whose leading one is at bit 31
    localparam logic [7:0] EXP_START = 8'd158;

    state_t      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [7:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic [31:0] answer_q, answer_d;

    // Input capture terms
    logic        in_sign;
    logic [31:0] in_mag;

    // Rounding terms
    logic        rnd_guard;
    logic        rnd_sticky;
    logic        rnd_lsb;
    logic        rnd_up;
    logic [23:0] rnd_sum;
    logic [22:0] rnd_mant;
    logic [7:0]  rnd_exp;

    // -2^31 negates to itself, which is the correct unsigned magnitude 0x80000000
    assign in_sign = (SIGNED_IN != 0) ? int_i[31] : 1'b0;
    assign in_mag  = in_sign ? (~int_i + 32'd1) : int_i;

    // Bit 31 is the implicit one; bits 30:8 are the kept mantissa
    assign rnd_guard  = mag_q[7];
    assign rnd_sticky = |mag_q[6:0];
    assign rnd_lsb    = mag_q[8];
    assign rnd_up     = rnd_guard & (rnd_sticky | rnd_lsb);
    assign rnd_sum    = {1'b0, mag_q[30:8]} + {23'd0, rnd_up};

    // Carry out of the mantissa means 1.111..1 rounded to 10.000..0
    assign rnd_mant = rnd_sum[22:0];
    assign rnd_exp  = rnd_sum[23] ? (exp_q + 8'd1) : exp_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            mag_q    <= 32'd0;
            exp_q    <= 8'd0;
            sign_q   <= 1'b0;
            answer_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            answer_q <= answer_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        answer_d = answer_q;

        case (state_q)
            IDLE: begin
                if (vld_i) begin
                    sign_d = in_sign;
                    mag_d  = in_mag;
                    exp_d  = EXP_START;
                    if (in_mag == 32'd0) begin
                        // Zero has no leading one; emit +0 directly
                        answer_d = 32'd0;
                        state_d  = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end
            end

            NORM: begin
                // Magnitude is nonzero here, so at most 31 shifts occur and
                // exp never drops below 127
                if (mag_q[31]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = {mag_q[30:0], 1'b0};
                    exp_d = exp_q - 8'd1;
                end
            end

            ROUND: begin
                answer_d = {sign_q, rnd_exp, rnd_mant};
                state_d  = DONE;
            end

            DONE: begin
                if (rdy_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rdy_o    = (state_q == IDLE);
    assign vld_o    = (state_q == DONE);
    assign answer_o = answer_q;

endmodule

// File: tb/tb_seq_int_to_fp_converter.sv
// ---------------------------------------------------------------------------
// Bench for seq_int_to_fp_converter. Instance 0 is signed, instance 1 is
// unsigned. Results and latencies are predicted by an arithmetic model that
// locates the leading one and rounds the discarded remainder half-to-even.
// Latency is counted in clock edges after the accept edge; a zero operand
// is loaded by the accept edge itself, so its count is 0.
// ---------------------------------------------------------------------------
module tb_seq_int_to_fp_converter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] int_in = 32'd0;
    logic        vld_in  [2];
    logic        rdy_in  [2];
    logic        rdy_out [2];
    logic        vld_out [2];
    logic [31:0] ans     [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    seq_int_to_fp_converter #(.SIGNED_IN(1)) dut_s (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .int_i    (int_in),
        .vld_i    (vld_in[0]),
        .rdy_o    (rdy_out[0]),
        .answer_o (ans[0]),
        .vld_o    (vld_out[0]),
        .rdy_i    (rdy_in[0])
    );

    seq_int_to_fp_converter #(.SIGNED_IN(0)) dut_u (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .int_i    (int_in),
        .vld_i    (vld_in[1]),
        .rdy_o    (rdy_out[1]),
        .answer_o (ans[1]),
        .vld_o    (vld_out[1]),
        .rdy_i    (rdy_in[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_mag(input logic [31:0] v, input bit signed_in);
        if (signed_in && v[31]) return 32'(-v);
        return v;
    endfunction

    function automatic int model_msb(input logic [31:0] m);
        for (int p = 31; p >= 0; p--)
            if (m[p]) return p;
        return -1;
    endfunction

    function automatic logic [31:0] model_fp(input logic [31:0] v, input bit signed_in);
        logic [31:0]     m;
        bit              s;
        int              p;
        int              e;
        int              sh;
        longint unsigned q;
        longint unsigned rem;
        longint unsigned half;
        logic [7:0]      e8;
        logic [22:0]     man;
        s = signed_in && v[31];
        m = model_mag(v, signed_in);
        if (m == 32'd0) return 32'd0;
        p = model_msb(m);
        e = 127 + p;
        if (p <= 23) begin
            q = longint'(m) << (23 - p);
        end else begin
            sh   = p - 23;
            q    = longint'(m) >> sh;
            rem  = longint'(m) & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        e8  = e[7:0];
        man = q[22:0];
        return {s, e8, man};
    endfunction

    function automatic int model_lat(input logic [31:0] v, input bit signed_in);
        logic [31:0] m;
        m = model_mag(v, signed_in);
        if (m == 32'd0) return 0;
        return (31 - model_msb(m)) + 2;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One conversion on instance d; result held for 'hold' cycles of backpressure
    task automatic run_one(input int d, input logic [31:0] v, input int hold, input string tag);
        int          lat;
        int          w;
        logic [31:0] exp_ans;
        exp_ans = model_fp(v, d == 0);
        w = 0;
        while (!rdy_out[d] && w < 50) begin
            tick();
            w++;
        end
        check({tag, "_rdy_wait"}, 32'(rdy_out[d]), 32'd1);
        rdy_in[d] = (hold == 0);
        int_in    = v;
        vld_in[d] = 1'b1;
        tick();
        vld_in[d] = 1'b0;
        int_in    = $urandom;
        lat = 0;
        while (!vld_out[d] && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(model_lat(v, d == 0)));
        check({tag, "_ans"}, ans[d], exp_ans);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_vld"}, 32'(vld_out[d]), 32'd1);
            check({tag, "_hold_ans"}, ans[d], exp_ans);
        end
        rdy_in[d] = 1'b1;
        tick();
        check({tag, "_release_rdy"}, 32'(rdy_out[d]), 32'd1);
        check({tag, "_release_vld"}, 32'(vld_out[d]), 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] bp_exp;
        logic [31:0] b2b_vals [4];
        logic [31:0] b2b_got  [$];
        int          hs_cyc   [$];
        int          acc_cyc  [$];
        int          idx;

        vld_in[0] = 1'b0;
        vld_in[1] = 1'b0;
        rdy_in[0] = 1'b1;
        rdy_in[1] = 1'b1;

        // Reset state
        #12;
        check("rst_rdy", 32'(rdy_out[0]), 32'd1);
        check("rst_vld", 32'(vld_out[0]), 32'd0);
        check("rst_ans", ans[0], 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        tick();

        // Directed values
        run_one(0, 32'h00000001, 0, "one");
        run_one(0, 32'hFFFFFFFF, 0, "minus_one");
        run_one(0, 32'h00000000, 0, "zero");
        run_one(0, 32'h80000000, 0, "min_int_s");
        run_one(1, 32'h80000000, 0, "min_int_u");
        run_one(1, 32'hFFFFFFFF, 0, "max_u");
        run_one(0, 32'h01000001, 0, "tie_even");
        run_one(0, 32'h01000003, 0, "tie_odd");
        run_one(0, 32'h7FFFFFFF, 0, "mant_carry");
        check("const_one", model_fp(32'h00000001, 1'b1), 32'h3F800000);

        // Backpressure with an ignored vld_i pulse
        bp_exp = model_fp(32'h12345678, 1'b1);
        rdy_in[0] = 1'b0;
        int_in    = 32'h12345678;
        vld_in[0] = 1'b1;
        tick();
        vld_in[0] = 1'b0;
        idx = 0;
        while (!vld_out[0] && idx < 40) begin
            tick();
            idx++;
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                int_in    = 32'hDEADBEEF;
                vld_in[0] = 1'b1;
            end else begin
                vld_in[0] = 1'b0;
            end
            tick();
            check("bp_vld", 32'(vld_out[0]), 32'd1);
            check("bp_ans", ans[0], bp_exp);
            check("bp_rdy", 32'(rdy_out[0]), 32'd0);
        end
        vld_in[0] = 1'b0;
        rdy_in[0] = 1'b1;
        tick();
        check("bp_release_rdy", 32'(rdy_out[0]), 32'd1);
        check("bp_release_vld", 32'(vld_out[0]), 32'd0);
        tick();
        check("bp_no_ghost", 32'(rdy_out[0]), 32'd1);

        // Back-to-back with vld_i held high
        b2b_vals[0] = 32'h00000007;
        b2b_vals[1] = 32'hFFFFF000;
        b2b_vals[2] = 32'h40000001;
        b2b_vals[3] = 32'h00000000;
        idx = 0;
        int_in    = b2b_vals[0];
        vld_in[0] = 1'b1;
        for (int cyc = 0; cyc < 300 && b2b_got.size() < 4; cyc++) begin
            bit accepting;
            accepting = rdy_out[0] && (idx < 4);
            if (accepting) acc_cyc.push_back(cyc);
            if (vld_out[0]) begin
                b2b_got.push_back(ans[0]);
                hs_cyc.push_back(cyc);
            end
            tick();
            if (accepting) begin
                idx++;
                if (idx < 4) int_in = b2b_vals[idx];
                else vld_in[0] = 1'b0;
            end
        end
        vld_in[0] = 1'b0;
        check("b2b_count", 32'(b2b_got.size()), 32'd4);
        for (int k = 0; k < b2b_got.size() && k < 4; k++)
            check("b2b_ans", b2b_got[k], model_fp(b2b_vals[k], 1'b1));
        for (int k = 0; k + 1 < acc_cyc.size() && k < hs_cyc.size(); k++)
            check("b2b_gap", 32'(acc_cyc[k + 1]), 32'(hs_cyc[k] + 1));
        tick();

        // Reset in the middle of NORM
        int_in    = 32'h00000001;
        vld_in[0] = 1'b1;
        tick();
        vld_in[0] = 1'b0;
        repeat (5) tick();
        check("pre_rst_busy", 32'(rdy_out[0]), 32'd0);
        rst_i = 1'b1;
        #1;
        check("mid_rst_vld", 32'(vld_out[0]), 32'd0);
        check("mid_rst_ans", ans[0], 32'd0);
        check("mid_rst_rdy", 32'(rdy_out[0]), 32'd1);
        tick();
        rst_i = 1'b0;
        tick();
        check("post_rst_vld", 32'(vld_out[0]), 32'd0);
        run_one(0, 32'h00000005, 0, "after_rst");
        check("const_five", model_fp(32'h00000005, 1'b1), 32'h40A00000);

        // Randomised operands across a spread of leading-zero counts
        for (int i = 0; i < 40; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = -v;
            run_one(0, v, $urandom_range(0, 3), "rand_s");
        end
        for (int i = 0; i < 20; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            run_one(1, v, $urandom_range(0, 2), "rand_u");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
